// File: rtl/seq_divider.sv
// Iterative signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per clock, followed by a single sign-fix cycle.
module seq_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             in_reset_n,
   input  logic             in_start,
   input  logic [WIDTH-1:0] in_dividend,
   input  logic [WIDTH-1:0] in_divisor,
   output logic [WIDTH-1:0] out_quotient,
   output logic [WIDTH-1:0] out_remainder,
   output logic             out_busy,
   output logic             out_done,
   output logic             out_div_by_zero
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
   logic             neg_quo_q, neg_rem_q, zero_q;

   logic [WIDTH:0]   shifted_d;
   logic [WIDTH-1:0] diff_d, rem_d;
   logic             ge_d;
   logic [WIDTH-1:0] dvd_mag_d, dvs_mag_d, quo_fix_d, rem_fix_d;

   always_comb begin
      dvd_mag_d = in_dividend[WIDTH-1] ? -in_dividend : in_dividend;
      dvs_mag_d = in_divisor[WIDTH-1]  ? -in_divisor  : in_divisor;
      shifted_d = {rem_q, quo_q[WIDTH-1]};
      ge_d      = shifted_d >= {1'b0, dvs_q};
      // A successful subtract always leaves a value below the divisor, so the
      // low WIDTH bits of the difference are exact.
      diff_d    = shifted_d[WIDTH-1:0] - dvs_q;
      rem_d     = ge_d ? diff_d : shifted_d[WIDTH-1:0];
      quo_fix_d = neg_quo_q ? -quo_q : quo_q;
      rem_fix_d = neg_rem_q ? -rem_q : rem_q;
   end

   always_ff @(posedge clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         quo_q           <= '0;
         rem_q           <= '0;
         dvs_q           <= '0;
         neg_quo_q       <= 1'b0;
         neg_rem_q       <= 1'b0;
         zero_q          <= 1'b0;
         out_quotient    <= '0;
         out_remainder   <= '0;
         out_busy        <= 1'b0;
         out_done        <= 1'b0;
         out_div_by_zero <= 1'b0;
      end else begin
         out_done <= 1'b0;
         if (in_start) begin
            // A start in any state recaptures operands and abandons any operation in flight.
            state_q   <= CALC;
            cnt_q     <= '0;
            quo_q     <= dvd_mag_d;
            rem_q     <= '0;
            dvs_q     <= dvs_mag_d;
            neg_quo_q <= in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1];
            neg_rem_q <= in_dividend[WIDTH-1];
            zero_q    <= (in_divisor == '0);
            out_busy  <= 1'b1;
         end else begin
            case (state_q)
               CALC: begin
                  rem_q <= rem_d;
                  quo_q <= {quo_q[WIDTH-2:0], ge_d};
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == LAST) state_q <= FIX;
               end
               FIX: begin
                  // With a zero divisor the remainder register ends up holding |dividend|.
                  out_quotient    <= zero_q ? '1 : quo_fix_d;
                  out_remainder   <= rem_fix_d;
                  out_div_by_zero <= zero_q;
                  out_done        <= 1'b1;
                  out_busy        <= 1'b0;
                  state_q         <= IDLE;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed corners plus random operands checked
// against a plain signed-arithmetic reference model.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        in_reset_n;
   logic        in_start;
   logic [31:0] in_dividend, in_divisor;
   logic [31:0] out_quotient, out_remainder;
   logic        out_busy, out_done, out_div_by_zero;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] last_q, last_r;
   logic        last_z;

   seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
      .clk             (clk),
      .in_reset_n      (in_reset_n),
      .in_start        (in_start),
      .in_dividend     (in_dividend),
      .in_divisor      (in_divisor),
      .out_quotient    (out_quotient),
      .out_remainder   (out_remainder),
      .out_busy        (out_busy),
      .out_done        (out_done),
      .out_div_by_zero (out_div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: truncating signed division in 64-bit arithmetic, so -2^31/-1 wraps naturally.
   task automatic model(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output logic z);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
         z = 1'b1;
      end else begin
         q = 32'(sa / sb);
         r = 32'(sa % sb);
         z = 1'b0;
      end
   endtask

   // Called at the negedge right after the last sampled start edge (E0).
   task automatic finish_op(input string tag, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eq, er;
      logic        ez;
      int bad_busy, bad_done, bad_hold;
      model(a, b, eq, er, ez);
      bad_busy = 0; bad_done = 0; bad_hold = 0;
      in_start    = 1'b0;
      in_dividend = $urandom;
      in_divisor  = $urandom;
      for (int k = 0; k <= 32; k++) begin
         if (k > 0) @(negedge clk);
         if (out_busy !== 1'b1) bad_busy++;
         if (out_done !== 1'b0) bad_done++;
         if (out_quotient !== last_q || out_remainder !== last_r || out_div_by_zero !== last_z)
            bad_hold++;
         if (k == 16) begin
            in_dividend = $urandom;
            in_divisor  = $urandom;
         end
      end
      check({tag, "_busy_calc"}, bad_busy, 0);
      check({tag, "_done_early"}, bad_done, 0);
      check({tag, "_hold"}, bad_hold, 0);
      @(negedge clk);
      check({tag, "_done"}, {31'd0, out_done}, 1);
      check({tag, "_busy_end"}, {31'd0, out_busy}, 0);
      check({tag, "_q"}, out_quotient, eq);
      check({tag, "_r"}, out_remainder, er);
      check({tag, "_dbz"}, {31'd0, out_div_by_zero}, {31'd0, ez});
      @(negedge clk);
      check({tag, "_done_drop"}, {31'd0, out_done}, 0);
      $display("op %s: %h / %h -> q=%h r=%h dbz=%0d", tag, a, b, out_quotient, out_remainder, out_div_by_zero);
      last_q = eq; last_r = er; last_z = ez;
   endtask

   // hold > 0 keeps in_start high for extra edges with junk operands first.
   task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b, input int hold);
      @(negedge clk);
      for (int h = 0; h < hold; h++) begin
         in_start    = 1'b1;
         in_dividend = $urandom;
         in_divisor  = $urandom;
         @(negedge clk);
      end
      in_start    = 1'b1;
      in_dividend = a;
      in_divisor  = b;
      @(negedge clk);
      finish_op(tag, a, b);
   endtask

   initial begin
      int bad;
      logic [31:0] ra, rb;
      in_reset_n  = 1'b0;
      in_start    = 1'b0;
      in_dividend = '0;
      in_divisor  = '0;
      last_q = '0; last_r = '0; last_z = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_q", out_quotient, 0);
      check("rst_r", out_remainder, 0);
      check("rst_flags", {29'd0, out_busy, out_done, out_div_by_zero}, 0);
      @(negedge clk);
      in_reset_n = 1'b1;

      op("t1_100_7", 32'd100, 32'd7, 0);
      op("t2_m100_7", -32'sd100, 32'd7, 0);
      op("t2_100_m7", 32'd100, -32'sd7, 0);
      op("t2_m100_m7", -32'sd100, -32'sd7, 0);
      op("t3_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 0);
      op("t3_5_9", 32'd5, 32'd9, 0);
      op("t3_m1_1", 32'hFFFF_FFFF, 32'd1, 0);
      op("t4_dbz", 32'd1234, 32'd0, 0);
      op("t4_10_3", 32'd10, 32'd3, 0);
      op("t4_negdbz", -32'sd77, 32'd0, 0);
      op("held_start", 32'd1000, 32'd33, 2);

      // Restart at edge 10 of a 100/7 operation.
      @(negedge clk);
      in_start = 1'b1; in_dividend = 32'd100; in_divisor = 32'd7;
      @(negedge clk);
      in_start = 1'b0; in_dividend = $urandom; in_divisor = $urandom;
      bad = 0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (out_done !== 1'b0) bad++;
      end
      check("t5_pre_done", bad, 0);
      in_start = 1'b1; in_dividend = 32'd50; in_divisor = 32'd5;
      @(negedge clk);
      finish_op("t5_restart", 32'd50, 32'd5);

      // Asynchronous reset just after edge 15 of a calculation.
      @(negedge clk);
      in_start = 1'b1; in_dividend = 32'd100; in_divisor = 32'd7;
      @(negedge clk);
      in_start = 1'b0;
      repeat (14) @(negedge clk);
      @(posedge clk);
      #2 in_reset_n = 1'b0;
      #1;
      check("t6_rst_q", out_quotient, 0);
      check("t6_rst_r", out_remainder, 0);
      check("t6_rst_flags", {29'd0, out_busy, out_done, out_div_by_zero}, 0);
      @(negedge clk);
      in_reset_n = 1'b1;
      last_q = '0; last_r = '0; last_z = 1'b0;
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_done !== 1'b0 || out_busy !== 1'b0) bad++;
      end
      check("t6_no_done", bad, 0);
      op("t6_9_2", 32'd9, 32'd2, 0);

      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         case (i % 4)
            0: rb = $urandom;
            1: rb = $urandom_range(0, 15);
            2: rb = -$urandom_range(1, 300);
            default: rb = (i == 7) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
         endcase
         op($sformatf("rnd%0d", i), ra, rb, (i % 5 == 0) ? 1 : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative signed 32-bit divider. It is the DIV engine behind the ALU, directly downstream of the control unit.
- The control unit holds the divide state. It pulses in_start (driven from out_div_reset) on the first cycle and waits a fixed 34 further cycles before reading Z.
- The block produces the quotient (to Z low, then LO) and the remainder (to Z high, then HI).
- Restoring shift-subtract on operand magnitudes, one quotient bit per clock, then a sign-fix cycle.

Parameters:
- WIDTH, 32, operand and result width (the datapath is fixed at 32; the parameter exists for unit-level testing).
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- in_reset_n  input  1  reset, asynchronous, active-low; clears all state.
- in_start  input  1  start/restart request, sampled on the rising edge.
- in_dividend  input  WIDTH  signed dividend (Y register); sampled only when in_start=1.
- in_divisor  input  WIDTH  signed divisor (bus); sampled only when in_start=1.
- out_quotient  output  WIDTH  signed quotient, registered.
- out_remainder  output  WIDTH  signed remainder, registered.
- out_busy  output  1  high while a division is in progress.
- out_done  output  1  one-cycle pulse: results updated this cycle.
- out_div_by_zero  output  1  sticky flag for the last completed operation.

Behaviour:
- Reset (in_reset_n=0, asynchronous):
  - state=IDLE; counter=0.
  - out_quotient=0, out_remainder=0, out_busy=0, out_done=0, out_div_by_zero=0.
  - Reset during CALC/FIX abandons the operation; no done pulse follows.
- States: IDLE, CALC, FIX.
- IDLE, in_start=1 at edge E0:
  - Capture |dividend| into the quotient shift register and |divisor| into the divisor register; partial remainder=0; counter=0.
  - Latch sign_q = dividend[MSB] XOR divisor[MSB], sign_r = dividend[MSB], zero flag = (divisor==0).
  - Go to CALC; out_busy=1.
- CALC, one iteration per edge (E1..E32):
  - Shift {rem,quo} left by 1.
  - If the shifted rem (WIDTH+1 bits) ≥ divisor magnitude: rem -= divisor and quo[0]=1; else quo[0]=0.
  - counter++.
  - Go to FIX after the edge where counter reaches WIDTH-1 (E32).
- FIX at edge E33:
  - out_quotient = sign_q ? -quo : quo; out_remainder = sign_r ? -rem : rem.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - out_div_by_zero = zero flag; out_done=1 for exactly this one cycle; out_busy=0; state=IDLE.
- Latency: in_start sampled at E0 gives results and done valid after E33 (33 cycles). This fits the control unit's 35-cycle divide window.
- Magnitude arithmetic is unsigned WIDTH bits, so |-2^31| = 0x80000000 is representable. Consequently 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no flag).
- Divide by zero:
  - Runs the full latency; no shortcut.
  - Forced results: out_quotient=32'hFFFFFFFF, out_remainder=dividend (as captured).
  - out_div_by_zero=1.
- in_start=1 while busy (CALC or FIX):
  - Aborts the current operation and recaptures operands at that edge; the counter restarts at 0.
  - No done pulse for the aborted operation.
- in_start held high: each edge restarts, so the operation completes only after in_start drops. Done therefore appears 33 edges after the last sampled start.
- Outputs out_quotient/out_remainder/out_div_by_zero hold their previous values until the next FIX edge.
- Operand inputs are ignored except at start edges; they may change freely during CALC.
- out_busy=1 from after E0 through E32, and 0 after E33.

Test Plan:
1. Reset, then start with 100 / 7 -> after exactly 33 edges: out_quotient=14, out_remainder=2; out_done high for one cycle; out_busy falls the same cycle; out_div_by_zero=0.
2. Signs: -100/7 -> q=0xFFFFFFF2, r=0xFFFFFFFE. 100/-7 -> q=0xFFFFFFF2, r=2. -100/-7 -> q=14, r=0xFFFFFFFE.
3. Corners:
   - 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
   - 5/9 -> q=0, r=5.
   - 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
4. 1234/0 -> after 33 edges: q=0xFFFFFFFF, r=1234, out_div_by_zero=1. A following 10/3 -> q=3, r=1, flag cleared.
5. Start 100/7, then assert in_start with 50/5 at edge 10 -> no done at edge 33 of the first operation; done 33 edges after the restart with q=10, r=0. Also change the operand inputs during CALC -> results unaffected.
6. Assert in_reset_n low asynchronously mid-CALC (edge 15) -> all outputs 0 immediately. Release, then start 9/2 -> q=4, r=1 after 33 edges.
